keypad_scanner: RTL and testbench

//   Front end for the 4x4 security keypad. Drives the one-hot column sweep, samples the row lines,

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/keypad_scanner_if.sv | 22 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/keypad_scanner.sv | 160 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the keypad front end and the passcode/arming block:
//   scan FSM states, key code type, column reset pattern, one-hot helpers and
//   the stored passcode digit codes.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  typedef logic [3:0] key_code_t;

  localparam logic [3:0] COL_RESET = 4'b1000;

  // Passcode digits as {row_idx,col_idx}
  localparam key_code_t DIGIT_1 = 4'b0000;
  localparam key_code_t DIGIT_8 = 4'b1001;
  localparam key_code_t DIGIT_6 = 4'b0110;
  localparam key_code_t DIGIT_5 = 4'b0101;

  // bit3 is line 0, so the index counts down from the MSB
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    case (oh)
      4'b1000: idx = 2'd0;
      4'b0100: idx = 2'd1;
      4'b0010: idx = 2'd2;
      4'b0001: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Keypad-side and key-event signals of the scanner.
//   row        raw row lines from the keypad (asynchronous, bit3 = row 0)
//   col        one-hot column drive (bit3 = col 0)
//   key_valid  single-cycle pulse per accepted press
//   key_code   {row_idx,col_idx} of the last accepted key
//   key_held   high from key_valid until the release is debounced
//   slave  : the scanner
//   master : the keypad / consumer side
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  key_code_t  key_code;
  logic       key_held;

  modport slave  (input  row, output col, key_valid, key_code, key_held);
  modport master (output row, input  col, key_valid, key_code, key_held);

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for asynchronous level inputs.
//   clk  in  clock
//   rst  in  asynchronous reset, active-low; clears both stages
//   d    in  asynchronous input
//   q    out synchronized output
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   4x4 keypad front end: sweeps the columns, synchronizes and debounces the
//   rows on both press and release, and emits one key_valid pulse per press.
//   clk   in  system clock, rising edge
//   rst   in  asynchronous reset, active-low
//   kp    keypad_scanner_if.slave (row in; col, key_valid, key_code, key_held out)
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   SCAN     | rotating columns, row_s checked on the last dwell cycle
//   DEBOUNCE | column frozen, counting samples equal to the captured row
//   PRESSED  | key accepted, waiting for the row lines to go quiet
//   RELEASE  | counting consecutive quiet samples before resuming the scan
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.slave   kp
);

  localparam int DW = $clog2(SCAN_DIV) + 1;
  localparam int CW = $clog2(DEBOUNCE_CNT) + 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  logic [3:0]    row_s;

  scan_state_t   state, state_nxt;
  logic [DW-1:0] dwell, dwell_nxt;
  logic [CW-1:0] deb_cnt, deb_nxt;
  logic [3:0]    col_q, col_nxt;
  logic [3:0]    row_cap, row_cap_nxt;
  logic [3:0]    col_cap, col_cap_nxt;
  logic          valid_q, valid_nxt;
  key_code_t     code_q, code_nxt;
  logic          held_q, held_nxt;

  logic [3:0]    col_rot;
  logic [CW-1:0] deb_inc;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (kp.row),
    .q   (row_s)
  );

  assign col_rot = {col_q[0], col_q[3:1]};
  assign deb_inc = (deb_cnt == CNT_MAX) ? deb_cnt : deb_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= SCAN;
      dwell   <= '0;
      deb_cnt <= '0;
      col_q   <= COL_RESET;
      row_cap <= 4'b0000;
      col_cap <= 4'b0000;
      valid_q <= 1'b0;
      code_q  <= 4'b0000;
      held_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      dwell   <= dwell_nxt;
      deb_cnt <= deb_nxt;
      col_q   <= col_nxt;
      row_cap <= row_cap_nxt;
      col_cap <= col_cap_nxt;
      valid_q <= valid_nxt;
      code_q  <= code_nxt;
      held_q  <= held_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dwell_nxt   = dwell;
    deb_nxt     = deb_cnt;
    col_nxt     = col_q;
    row_cap_nxt = row_cap;
    col_cap_nxt = col_cap;
    valid_nxt   = 1'b0;
    code_nxt    = code_q;
    held_nxt    = held_q;

    case (state)
      SCAN: begin
        // Rows get SCAN_DIV-1 cycles (two of them in the synchronizer) to
        // settle after a column change before they are looked at.
        if (dwell == DWELL_LAST) begin
          dwell_nxt = '0;
          if (is_onehot(row_s)) begin
            row_cap_nxt = row_s;
            col_cap_nxt = col_q;
            deb_nxt     = '0;
            state_nxt   = DEBOUNCE;
          end else begin
            // Nothing pressed, or a ghost pattern with two rows in this column
            col_nxt = col_rot;
          end
        end else begin
          dwell_nxt = dwell + DW'(1);
        end
      end

      DEBOUNCE: begin
        if (row_s == row_cap) begin
          deb_nxt = deb_inc;
          if (deb_cnt == DEB_LAST) begin
            valid_nxt = 1'b1;
            code_nxt  = {onehot_to_idx(row_cap), onehot_to_idx(col_cap)};
            held_nxt  = 1'b1;
            state_nxt = PRESSED;
          end
        end else begin
          state_nxt = SCAN;
          col_nxt   = col_rot;
          dwell_nxt = '0;
        end
      end

      PRESSED: begin
        // Column stays frozen, so a second key elsewhere is invisible and a
        // second key in this column only keeps the rows busy.
        if (row_s == 4'b0000) begin
          deb_nxt   = '0;
          state_nxt = RELEASE;
        end
      end

      RELEASE: begin
        if (row_s == 4'b0000) begin
          deb_nxt = deb_inc;
          if (deb_cnt == DEB_LAST) begin
            held_nxt  = 1'b0;
            state_nxt = SCAN;
            col_nxt   = col_rot;
            dwell_nxt = '0;
          end
        end else begin
          state_nxt = PRESSED;
        end
      end

      default: state_nxt = SCAN;
    endcase
  end

  assign kp.col       = col_q;
  assign kp.key_valid = valid_q;
  assign kp.key_code  = code_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed and randomized press/release scenarios on a modelled 4x4 keypad,
//   checked every cycle against a behavioural model of the scanner.
module tb_keypad_scanner;

  localparam int SDIV = 4;
  localparam int DCNT = 8;

  // model activity phases
  localparam int M_SWEEP   = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_HOLD    = 2;
  localparam int M_LETGO   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_DIV(SDIV), .DEBOUNCE_CNT(DCNT)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // keypad: pressed row pattern per column index
  logic [3:0] pressed_rows [4];

  // behavioural model
  int         m_mode, m_phase, m_col, m_hits, m_row, m_cap_col;
  logic [3:0] m_sync [2];
  logic       m_valid, m_held;
  logic [3:0] m_code;

  int         pulses;
  logic [3:0] codes [$];

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int row_index(input logic [3:0] r);
    int cnt = 0;
    int idx = -1;
    for (int b = 0; b < 4; b++)
      if (r[3-b]) begin cnt++; idx = b; end
    return (cnt == 1) ? idx : -1;
  endfunction

  function automatic logic [3:0] last_code();
    if (codes.size() == 0) return 4'bxxxx;
    return codes[codes.size()-1];
  endfunction

  task automatic model_reset();
    m_mode = M_SWEEP; m_phase = 0; m_col = 0; m_hits = 0; m_row = 0; m_cap_col = 0;
    m_sync[0] = 4'b0; m_sync[1] = 4'b0;
    m_valid = 1'b0; m_held = 1'b0; m_code = 4'b0;
  endtask

  task automatic model_edge();
    logic [3:0] rs;
    if (!rst) begin
      model_reset();
      return;
    end
    rs = m_sync[1];
    m_valid = 1'b0;
    case (m_mode)
      M_SWEEP: begin
        if (m_phase == SDIV-1) begin
          m_phase = 0;
          if (row_index(rs) >= 0) begin
            m_row = row_index(rs); m_cap_col = m_col; m_hits = 0; m_mode = M_CONFIRM;
          end else m_col = (m_col + 1) % 4;
        end else m_phase++;
      end
      M_CONFIRM: begin
        if (rs == (4'b1000 >> m_row)) begin
          m_hits++;
          if (m_hits == DCNT) begin
            m_valid = 1'b1; m_held = 1'b1; m_code = 4'(m_row*4 + m_cap_col); m_mode = M_HOLD;
          end
        end else begin
          m_mode = M_SWEEP; m_col = (m_col + 1) % 4; m_phase = 0;
        end
      end
      M_HOLD: if (rs == 4'b0) begin m_hits = 0; m_mode = M_LETGO; end
      default: begin
        if (rs == 4'b0) begin
          m_hits++;
          if (m_hits == DCNT) begin
            m_held = 1'b0; m_mode = M_SWEEP; m_col = (m_col + 1) % 4; m_phase = 0;
          end
        end else m_mode = M_HOLD;
      end
    endcase
    m_sync[1] = m_sync[0];
    m_sync[0] = kp.row;
  endtask

  task automatic drive_row();
    logic [3:0] r;
    r = 4'b0;
    for (int c = 0; c < 4; c++)
      if (kp.col[3-c] === 1'b1) r |= pressed_rows[c];
    kp.row = r;
  endtask

  task automatic press(input int r, input int c);
    pressed_rows[c] |= (4'b1000 >> r);
    drive_row();
  endtask

  task automatic release_all();
    for (int c = 0; c < 4; c++) pressed_rows[c] = 4'b0;
    drive_row();
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("col", kp.col, 4'b1000 >> m_col);
      chk("key_valid", kp.key_valid, m_valid);
      chk("key_code", kp.key_code, m_code);
      chk("key_held", kp.key_held, m_held);
      if (kp.key_valid === 1'b1) begin
        pulses++;
        codes.push_back(kp.key_code);
      end
      drive_row();
    end
  endtask

  task automatic wait_mode(input int m, input int budget);
    int k = 0;
    while (m_mode != m && k < budget) begin step(1); k++; end
    chk("wait_mode", 4'(m_mode), 4'(m));
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_col", kp.col, 4'b1000);
    chk("rst_valid", kp.key_valid, 1'b0);
    chk("rst_code", kp.key_code, 4'b0000);
    chk("rst_held", kp.key_held, 1'b0);
    model_reset();
    drive_row();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq_exp [4];
    int         seq_r [4];
    int         seq_c [4];
    int         r, c, r2, c2;

    seq_exp[0] = 4'b0000; seq_exp[1] = 4'b1001; seq_exp[2] = 4'b0110; seq_exp[3] = 4'b0101;
    seq_r[0] = 0; seq_c[0] = 0;
    seq_r[1] = 2; seq_c[1] = 1;
    seq_r[2] = 1; seq_c[2] = 2;
    seq_r[3] = 1; seq_c[3] = 1;

    pulses = 0;
    kp.row = 4'b0;
    for (int i = 0; i < 4; i++) pressed_rows[i] = 4'b0;

    // 1: reset values, then the column sweep, then a mid-run reset
    async_reset();
    step(3);
    rst = 1'b1;
    step(22);
    async_reset();
    step(2);
    rst = 1'b1;
    step(8);

    // 2: clean press of digit 8
    pulses = 0;
    press(2, 1);
    step(40);
    chk("p8_pulses", 4'(pulses), 4'd1);
    chk("p8_code", last_code(), 4'b1001);
    chk("p8_held", kp.key_held, 1'b1);
    chk("p8_col", kp.col, 4'b0100);
    release_all();
    wait_mode(M_SWEEP, 60);
    step(4);

    // 3: press bounce
    pulses = 0;
    press(2, 1);
    wait_mode(M_CONFIRM, 80);
    step(2);
    release_all();
    wait_mode(M_SWEEP, 20);
    chk("bounce_col", kp.col, 4'b0010);
    step(40);
    chk("bounce_pulses", 4'(pulses), 4'd0);

    // 4: release bounce
    pulses = 0;
    press(2, 1);
    wait_mode(M_HOLD, 80);
    step(3);
    release_all();
    step(5);
    press(2, 1);
    step(4);
    release_all();
    step(10);
    chk("rel_held_before", kp.key_held, 1'b1);
    step(1);
    chk("rel_held_after", kp.key_held, 1'b0);
    chk("rel_col", kp.col, 4'b0010);
    chk("rel_pulses", 4'(pulses), 4'd1);
    step(8);

    // 5: ghost pattern in column 0, then the passcode sequence
    pulses = 0;
    pressed_rows[0] = 4'b1010;
    drive_row();
    step(40);
    chk("ghost_pulses", 4'(pulses), 4'd0);
    release_all();
    step(8);
    codes.delete();
    for (int i = 0; i < 4; i++) begin
      press(seq_r[i], seq_c[i]);
      wait_mode(M_HOLD, 80);
      step(5);
      release_all();
      wait_mode(M_SWEEP, 60);
      step(4);
    end
    chk("seq_count", 4'(codes.size()), 4'd4);
    for (int i = 0; i < 4; i++)
      chk("seq_code", (i < codes.size()) ? codes[i] : 4'bxxxx, seq_exp[i]);

    // 6: reset in the middle of debounce
    pulses = 0;
    press(1, 2);
    begin
      int k = 0;
      while (!(m_mode == M_CONFIRM && m_hits == 5) && k < 80) begin step(1); k++; end
      chk("deb_hits", 4'(m_hits), 4'd5);
    end
    async_reset();
    release_all();
    step(3);
    rst = 1'b1;
    step(20);
    chk("rstdeb_pulses", 4'(pulses), 4'd0);
    press(1, 2);
    wait_mode(M_HOLD, 80);
    step(2);
    chk("fresh_pulses", 4'(pulses), 4'd1);
    chk("fresh_code", last_code(), 4'b0110);
    release_all();
    wait_mode(M_SWEEP, 60);

    // randomized presses with extra keys and release bounce
    for (int it = 0; it < 12; it++) begin
      pulses = 0;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      step($urandom_range(0, 15));
      press(r, c);
      wait_mode(M_HOLD, 80);
      step($urandom_range(0, 20));
      if ($urandom_range(0, 1) == 1) begin
        r2 = $urandom_range(0, 3);
        c2 = $urandom_range(0, 3);
        press(r2, c2);
        step($urandom_range(1, 10));
      end
      if ($urandom_range(0, 1) == 1) begin
        release_all();
        step($urandom_range(1, 6));
        press(r, c);
        step($urandom_range(2, 8));
      end
      release_all();
      wait_mode(M_SWEEP, 80);
      step($urandom_range(1, 6));
      chk("rand_pulses", 4'(pulses), 4'd1);
      chk("rand_code", last_code(), 4'(r*4 + c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
